// File: rtl/cnn_frame_streamer.sv
// rtl/cnn_frame_streamer.sv - one-frame pixel buffer between the byte link and cnn_core_top
//
// Purpose: accepts PIX_W-bit pixels over a valid/ready handshake into an N_PIX-deep buffer,
// replays the full frame to the core as one contiguous data_valid burst, waits for the core's
// decision (with a timeout) and holds it on a valid/ready result port tagged with a frame index.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   s_data, s_valid, s_ready        upstream pixel stream (s_ready high only while filling)
//   m_data_in, m_data_valid         pixel burst to cnn_core_top
//   core_decision, core_out_valid   decision returned by cnn_core_top
//   res_decision, res_idx,
//   res_valid, res_ready            captured result and its frame index, held until consumed
//   err_timeout, err_spurious       sticky error flags, cleared only by reset
module cnn_frame_streamer #(
  parameter int N_PIX       = 784,
  parameter int PIX_W       = 8,
  parameter int CLS_W       = 4,
  parameter int TIMEOUT_CYC = 8192,
  parameter int IDX_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [PIX_W-1:0] m_data_in,
  output logic             m_data_valid,
  input  logic [CLS_W-1:0] core_decision,
  input  logic             core_out_valid,
  output logic [CLS_W-1:0] res_decision,
  output logic [IDX_W-1:0] res_idx,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             err_timeout,
  output logic             err_spurious
);

  localparam int PTR_W = $clog2(N_PIX);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_PIX - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_FULL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [IDX_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             s_ready_q, s_ready_d;
  logic             m_data_valid_q, m_data_valid_d;
  logic             res_valid_q, res_valid_d;
  logic [CLS_W-1:0] res_decision_q, res_decision_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_spurious_q, err_spurious_d;

  logic [PIX_W-1:0] mem [N_PIX];
  logic [PIX_W-1:0] rd_data_q;
  logic             wr_en;
  logic             accept;
  logic             slot_free;

  assign accept    = s_valid && s_ready_q;
  // The result slot is usable this cycle if empty or being drained right now.
  assign slot_free = !res_valid_q || res_ready;

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    tmo_d          = tmo_q;
    frame_cnt_d    = frame_cnt_q;
    res_valid_d    = res_valid_q;
    res_decision_d = res_decision_q;
    res_idx_d      = res_idx_q;
    err_timeout_d  = err_timeout_q;
    err_spurious_d = err_spurious_q;
    wr_en          = 1'b0;

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
    if (core_out_valid && (state_q != ST_WAIT)) begin
      err_spurious_d = 1'b1;
    end

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (wr_ptr_q == PTR_LAST) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = slot_free ? ST_STREAM : ST_FULL;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      ST_FULL: begin
        if (slot_free) begin
          rd_ptr_d = '0;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (rd_ptr_q == PTR_LAST) begin
          rd_ptr_d = '0;
          tmo_d    = '0;
          state_d  = ST_WAIT;
        end else begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
      end
      ST_WAIT: begin
        // A response in the expiry cycle still counts as a result.
        if (core_out_valid) begin
          res_valid_d    = 1'b1;
          res_decision_d = core_decision;
          res_idx_d      = frame_cnt_q;
          frame_cnt_d    = frame_cnt_q + IDX_W'(1);
          tmo_d          = '0;
          state_d        = ST_FILL;
        end else if (tmo_q == TMO_LAST) begin
          err_timeout_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + IDX_W'(1);
          tmo_d         = '0;
          state_d       = ST_FILL;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ST_FILL;
    endcase

    // Output valid trails the RAM read issued in STREAM by one cycle.
    m_data_valid_d = (state_q == ST_STREAM);
    s_ready_d      = (state_d == ST_FILL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_FILL;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      tmo_q          <= '0;
      frame_cnt_q    <= '0;
      s_ready_q      <= 1'b0;
      m_data_valid_q <= 1'b0;
      res_valid_q    <= 1'b0;
      res_decision_q <= '0;
      res_idx_q      <= '0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      tmo_q          <= tmo_d;
      frame_cnt_q    <= frame_cnt_d;
      s_ready_q      <= s_ready_d;
      m_data_valid_q <= m_data_valid_d;
      res_valid_q    <= res_valid_d;
      res_decision_q <= res_decision_d;
      res_idx_q      <= res_idx_d;
      err_timeout_q  <= err_timeout_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  // Frame buffer: no reset on contents; writes are suppressed while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_ptr_q] <= s_data;
    end
    rd_data_q <= mem[rd_ptr_q];
  end

  assign s_ready      = s_ready_q;
  assign m_data_valid = m_data_valid_q;
  assign m_data_in    = m_data_valid_q ? rd_data_q : '0;
  assign res_valid    = res_valid_q;
  assign res_decision = res_decision_q;
  assign res_idx      = res_idx_q;
  assign err_timeout  = err_timeout_q;
  assign err_spurious = err_spurious_q;

endmodule
